mac_qadapt: RTL and testbench

- Adaptive slotted-ALOHA access controller for the tag modulator path; successor to the fixed-window LFSR gate.
- Per frame, draws a Q-bit random slot from a parametrised Fibonacci LFSR and counts down external slot ticks.
- Asserts `out` (modulation grant) in the chosen slot.
- Adapts Q at runtime from reader feedback: collision increases Q, sustained success decreases it.

---
 rtl/mac_qadapt_pkg.sv | 16 +
 rtl/mac_qadapt_lfsr.sv | 38 +++
 rtl/mac_qadapt.sv | 119 +++++++++++
 tb/tb_mac_qadapt.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_qadapt_pkg.sv
// Shared definitions for the adaptive slotted-ALOHA access controller.
// Holds the FSM state type and the default LFSR seed/tap constants.
package mac_pkg;

   localparam int unsigned QW            = 4;
   localparam logic [15:0] MAC_SEED_DEF  = 16'h4C06;
   localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      WAIT = 2'd2,
      TX   = 2'd3
   } mac_state_e;

endpackage

// File: rtl/mac_qadapt_lfsr.sv
// Fibonacci LFSR: shifts left, new LSB is the XOR of the stages selected by TAPS.
// load reloads SEED and has priority over step; reusable by other tag blocks.
module lfsr_gen #(
   parameter int unsigned W        = 16,
   parameter logic [W-1:0] TAPS    = W'(mac_pkg::LFSR_TAPS_DEF),
   parameter logic [W-1:0] SEED    = W'(mac_pkg::MAC_SEED_DEF)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   output logic [W-1:0] state
);

   logic [W-1:0] state_q, state_d;
   logic         fb;

   always_comb begin
      fb      = ^(state_q & TAPS);
      state_d = state_q;
      if (load) begin
         state_d = SEED;
      end else if (step) begin
         state_d = {state_q[W-2:0], fb};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mac_qadapt.sv
// Adaptive slotted-ALOHA access controller: draws a Q-bit slot per frame,
// grants modulation in that slot and adapts Q from reader feedback.
module mac_qadapt #(
   parameter int unsigned          LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]    LFSR_TAPS = LFSR_W'(mac_pkg::LFSR_TAPS_DEF),
   parameter logic [LFSR_W-1:0]    MAC_SEED  = LFSR_W'(mac_pkg::MAC_SEED_DEF),
   parameter int unsigned          QW        = mac_pkg::QW,
   parameter int unsigned          Q_INIT    = 0,
   parameter int unsigned          Q_MIN     = 0,
   parameter int unsigned          Q_MAX     = 8,
   parameter int unsigned          DEC_AFTER = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          frame_start,
   input  logic          slot_tick,
   input  logic          fb_valid,
   input  logic          fb_collision,
   output logic          out,
   output logic          tx_done,
   output logic          busy,
   output logic [QW-1:0] q_cur,
   output logic [QW-1:0] slot_rem
);

   import mac_pkg::*;

   localparam int unsigned SW = (DEC_AFTER > 1) ? $clog2(DEC_AFTER) : 1;

   mac_state_e        state_q, state_d;
   logic [QW-1:0]     q_q, q_d;
   logic [QW-1:0]     slot_rem_q, slot_rem_d;
   logic [SW-1:0]     succ_q, succ_d;
   logic              out_q, out_d;
   logic              tx_done_q, tx_done_d;
   logic [LFSR_W-1:0] lfsr_val;
   logic [LFSR_W-1:0] draw_mask;
   logic [QW-1:0]     draw;

   lfsr_gen #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS),
      .SEED (MAC_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (!enable),
      .step  (enable),
      .state (lfsr_val)
   );

   always_comb begin
      // q=0 yields an all-zero mask; draws wider than QW are truncated
      draw_mask  = (LFSR_W'(1) << q_q) - LFSR_W'(1);
      draw       = QW'(lfsr_val & draw_mask);
      state_d    = state_q;
      q_d        = q_q;
      slot_rem_d = slot_rem_q;
      succ_d     = succ_q;
      tx_done_d  = 1'b0;
      if (!enable) begin
         state_d    = IDLE;
         slot_rem_d = '0;
      end else begin
         unique case (state_q)
            IDLE: if (frame_start) state_d = DRAW;
            DRAW: begin
               slot_rem_d = draw;
               state_d    = (draw == '0) ? TX : WAIT;
            end
            WAIT: if (slot_tick) begin
               slot_rem_d = slot_rem_q - QW'(1);
               if (slot_rem_q == QW'(1)) state_d = TX;
            end
            TX: if (fb_valid) begin
               tx_done_d = 1'b1;
               state_d   = IDLE;
               if (fb_collision) begin
                  q_d    = (q_q >= QW'(Q_MAX)) ? QW'(Q_MAX) : q_q + QW'(1);
                  succ_d = '0;
               end else if (succ_q >= SW'(DEC_AFTER - 1)) begin
                  q_d    = (q_q <= QW'(Q_MIN)) ? QW'(Q_MIN) : q_q - QW'(1);
                  succ_d = '0;
               end else begin
                  succ_d = succ_q + SW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      out_d = (state_d == TX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         q_q        <= QW'(Q_INIT);
         slot_rem_q <= '0;
         succ_q     <= '0;
         out_q      <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         slot_rem_q <= slot_rem_d;
         succ_q     <= succ_d;
         out_q      <= out_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign out      = out_q;
   assign tx_done  = tx_done_q;
   assign busy     = (state_q != IDLE);
   assign q_cur    = q_q;
   assign slot_rem = slot_rem_q;

endmodule

// File: tb/tb_mac_qadapt.sv
// Scoreboard bench for mac_qadapt: stimulus pushes expected grant-rise and
// feedback events; a negedge monitor pops and compares when the DUT presents them.
module tb_mac_qadapt;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       frame_start;
   logic       slot_tick;
   logic       fb_valid;
   logic       fb_collision;
   logic       out;
   logic       tx_done;
   logic       busy;
   logic [3:0] q_cur;
   logic [3:0] slot_rem;

   mac_qadapt #(
      .Q_MAX     (3),
      .DEC_AFTER (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .frame_start  (frame_start),
      .slot_tick    (slot_tick),
      .fb_valid     (fb_valid),
      .fb_collision (fb_collision),
      .out          (out),
      .tx_done      (tx_done),
      .busy         (busy),
      .q_cur        (q_cur),
      .slot_rem     (slot_rem)
   );

   typedef struct {
      int cyc;
      int q;
   } sb_t;

   sb_t         sb_q[$];
   int          rise_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc;
   int          qm;
   logic [15:0] m_lfsr;
   logic        out_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference LFSR from the polynomial x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       m_lfsr <= 16'h4C06;
      else if (!enable) m_lfsr <= 16'h4C06;
      else              m_lfsr <= lfsr_next(m_lfsr);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (tx_done) begin
         if (sb_q.size() == 0) begin
            chk("tx_done_unexpected", 1, 0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("tx_done_cycle", cyc, e.cyc);
            chk("tx_done_q", int'(q_cur), e.q);
            chk("tx_done_out", int'(out), 0);
            chk("tx_done_busy", int'(busy), 0);
         end
      end
      if (out && !out_prev) begin
         if (rise_q.size() == 0) chk("out_rise_unexpected", 1, 0);
         else                    chk("out_rise_cycle", cyc, rise_q.pop_front());
      end
      out_prev = out;
   end

   // mode 0: normal feedback; 1: enable drops with fb_valid in TX; 2: async reset in TX
   task automatic run_frame(input bit coll, input int expq, input int force_k, input int mode);
      int k;
      enable      = 1'b1;
      frame_start = 1'b1;
      next();
      frame_start = 1'b0;
      chk("busy_draw", int'(busy), 1);
      chk("out_draw", int'(out), 0);
      k = (force_k >= 0) ? force_k : int'(m_lfsr & ((16'd1 << qm) - 16'd1));
      if (k == 0) rise_q.push_back(cyc + 1);
      next();
      chk("draw_value", int'(slot_rem), k);
      for (int i = 0; i < k; i++) begin
         frame_start = 1'b1;
         next();
         frame_start = 1'b0;
         chk("wait_hold", int'(slot_rem), k - i);
         repeat (3) next();
         slot_tick   = 1'b1;
         frame_start = 1'b1;
         if (i == k - 1) rise_q.push_back(cyc + 1);
         next();
         slot_tick   = 1'b0;
         frame_start = 1'b0;
         chk("wait_tick", int'(slot_rem), k - 1 - i);
      end
      chk("out_tx", int'(out), 1);
      slot_tick    = 1'b1;
      frame_start  = 1'b1;
      fb_collision = 1'b1;
      next();
      slot_tick    = 1'b0;
      frame_start  = 1'b0;
      fb_collision = 1'b0;
      chk("tx_spurious_out", int'(out), 1);
      chk("tx_spurious_busy", int'(busy), 1);
      chk("tx_spurious_rem", int'(slot_rem), 0);
      if (mode == 0) begin
         fb_valid     = 1'b1;
         fb_collision = coll;
         sb_q.push_back('{cyc: cyc + 1, q: expq});
         next();
         fb_valid     = 1'b0;
         fb_collision = 1'b0;
         qm = expq;
         next();
         chk("idle_after_fb", int'(busy), 0);
      end else if (mode == 1) begin
         enable       = 1'b0;
         fb_valid     = 1'b1;
         fb_collision = coll;
         next();
         enable       = 1'b1;
         fb_valid     = 1'b0;
         fb_collision = 1'b0;
         chk("abort_tx_done", int'(tx_done), 0);
         chk("abort_tx_q", int'(q_cur), qm);
         chk("abort_tx_busy", int'(busy), 0);
         chk("abort_tx_out", int'(out), 0);
      end else begin
         #2;
         rst_n = 1'b0;
         #1;
         chk("rst_tx_out", int'(out), 0);
         chk("rst_tx_busy", int'(busy), 0);
         chk("rst_tx_q", int'(q_cur), 0);
         chk("rst_tx_rem", int'(slot_rem), 0);
         fb_valid = 1'b1;
         next();
         fb_valid = 1'b0;
         next();
         rst_n = 1'b1;
         qm = 0;
         next();
         chk("rst_release_q", int'(q_cur), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit coll_tab[16];
      int q_tab[16];
      int bad;
      rst_n = 1'b1; enable = 1'b1; frame_start = 1'b0; slot_tick = 1'b0;
      fb_valid = 1'b0; fb_collision = 1'b0; qm = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", int'(out), 0);
      chk("rst_tx_done", int'(tx_done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_q", int'(q_cur), 0);
      chk("rst_slot_rem", int'(slot_rem), 0);
      rst_n = 1'b1;
      while (cyc < 10) next();

      // q=0: grant two cycles after frame_start, success keeps q at 0
      run_frame(1'b0, 0, -1, 0);

      fb_valid = 1'b1; fb_collision = 1'b1;
      next();
      fb_valid = 1'b0; fb_collision = 1'b0;
      chk("idle_fb_q", int'(q_cur), 0);
      chk("idle_fb_tx_done", int'(tx_done), 0);

      // collisions: 1, 2, 3, then saturate at Q_MAX=3
      run_frame(1'b1, 1, -1, 0);
      run_frame(1'b1, 2, -1, 0);
      run_frame(1'b1, 3, -1, 0);
      run_frame(1'b1, 3, -1, 0);

      // reload then draw: LFSR 0x4C06 -> 0x980D, low 3 bits = 5
      enable = 1'b0;
      next();
      enable = 1'b1; frame_start = 1'b1;
      next();
      frame_start = 1'b0;
      next();
      chk("abort_pre_rem", int'(slot_rem), 5);
      chk("abort_pre_busy", int'(busy), 1);
      enable = 1'b0;
      next();
      chk("abort_wait_busy", int'(busy), 0);
      chk("abort_wait_out", int'(out), 0);
      chk("abort_wait_rem", int'(slot_rem), 0);
      chk("abort_wait_q", int'(q_cur), 3);
      run_frame(1'b1, 3, 5, 0);

      run_frame(1'b0, 0, -1, 1);

      // successes: decrement every 4th, holding at Q_MIN=0
      q_tab = '{3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      coll_tab = '{default: 1'b0};
      for (int i = 0; i < 16; i++) run_frame(coll_tab[i], q_tab[i], -1, 0);

      run_frame(1'b1, 1, -1, 0);
      run_frame(1'b0, 0, -1, 2);

      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         next();
         if (dut.lfsr_val == 16'h0 || dut.lfsr_val !== m_lfsr) bad++;
      end
      chk("lfsr_1000_steps", bad, 0);

      repeat (3) next();
      chk("sb_drained", sb_q.size(), 0);
      chk("rise_drained", rise_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
